// File: rtl/pipe_stage_reg_if.sv
// Valid/ready channel carrying a control bundle and a data bundle between two pipeline stages.
// The master drives the bundle and valid; the slave drives ready.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 101
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer: registered ready, full throughput,
// flush to bubble, and control bits forced to zero whenever no valid bundle is held.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 101
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    pipe_stage_reg_if.slave         upstream,
    pipe_stage_reg_if.master        downstream,
    output logic [1:0]              occupancy
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CTRL_W-1:0] main_ctrl_p0;
    logic [DATA_W-1:0] main_data_p0;
    logic [CTRL_W-1:0] skid_ctrl_p0;
    logic [DATA_W-1:0] skid_data_p0;

    logic acc;
    logic fire;

    // Handshake terms depend only on the state register, never on each other combinationally.
    assign acc  = upstream.valid & (state != FULL);
    assign fire = (state != EMPTY) & downstream.ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (acc) state_next = ONE;
                ONE: begin
                    if (acc && !fire)      state_next = FULL;
                    else if (!acc && fire) state_next = EMPTY;
                end
                FULL:    if (fire) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        upstream.ready   = (state != FULL);
        downstream.valid = (state != EMPTY);
        occupancy        = state;
    end

    assign downstream.ctrl = main_ctrl_p0;
    assign downstream.data = main_data_p0;

    // Main register feeds the outputs; skid catches the bundle that arrives while the output stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_ctrl_p0 <= '0;
            main_data_p0 <= '0;
            skid_ctrl_p0 <= '0;
            skid_data_p0 <= '0;
        end else if (flush) begin
            main_ctrl_p0 <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_ctrl_p0 <= upstream.ctrl;
                        main_data_p0 <= upstream.data;
                    end
                end
                ONE: begin
                    if (acc && fire) begin
                        main_ctrl_p0 <= upstream.ctrl;
                        main_data_p0 <= upstream.data;
                    end else if (acc) begin
                        skid_ctrl_p0 <= upstream.ctrl;
                        skid_data_p0 <= upstream.data;
                    end else if (fire) begin
                        main_ctrl_p0 <= '0;
                    end
                end
                FULL: begin
                    if (fire) begin
                        main_ctrl_p0 <= skid_ctrl_p0;
                        main_data_p0 <= skid_data_p0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a FIFO-of-bundles reference model.
module tb_pipe_stage_reg;
    localparam int CW = 8;
    localparam int DW = 101;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn ();

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .upstream   (up.slave),
        .downstream (dn.master),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } bundle_t;

    // Reference model: the stage is a FIFO of at most two bundles; head is what the output shows.
    bundle_t q[$];
    logic    chk_en = 1'b0;
    logic    macc, mfire;

    always @(posedge clk) begin
        macc  = up.valid && (q.size() < 2);
        mfire = (q.size() > 0) && dn.ready;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (mfire) void'(q.pop_front());
            if (macc) q.push_back('{up.ctrl, up.data});
        end
        #1;
        if (chk_en) begin
            chk("model_out_valid", dn.valid, q.size() > 0);
            chk("model_in_ready", up.ready, q.size() < 2);
            chk("model_occupancy", occupancy, q.size());
            chk("model_out_ctrl", dn.ctrl, (q.size() > 0) ? q[0].c : '0);
            chk("inv_ready_vs_occ", up.ready, occupancy != 2'd2);
            if (q.size() > 0) chk("model_out_data", dn.data, q[0].d);
        end
    end

    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
        up.valid = 1'b1;
        up.ctrl  = c;
        up.data  = d;
    endtask

    logic [127:0] rnd;

    initial begin
        reset = 1'b1; flush = 1'b0;
        up.valid = 1'b0; up.ctrl = '0; up.data = '0; dn.ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", dn.valid, 1'b0);
        chk("rst_out_ctrl", dn.ctrl, 8'h00);
        chk("rst_out_data", dn.data, '0);
        chk("rst_occupancy", occupancy, 2'd0);
        chk("rst_in_ready", up.ready, 1'b1);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Single bundle straight through
        send(8'h5A, 101'h1234); dn.ready = 1'b1;
        @(negedge clk);
        chk("t1_out_valid", dn.valid, 1'b1);
        chk("t1_out_ctrl", dn.ctrl, 8'h5A);
        chk("t1_out_data", dn.data, 101'h1234);
        chk("t1_occ_one", occupancy, 2'd1);
        up.valid = 1'b0;
        @(negedge clk);
        chk("t1_occ_zero", occupancy, 2'd0);
        chk("t1_ctrl_cleared", dn.ctrl, 8'h00);

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            send(CW'(i), DW'(32'h100 + i));
            @(negedge clk);
            chk("t2_ctrl", dn.ctrl, CW'(i));
            chk("t2_data", dn.data, DW'(32'h100 + i));
            chk("t2_occ", occupancy, 2'd1);
            chk("t2_in_ready", up.ready, 1'b1);
        end
        up.valid = 1'b0;
        @(negedge clk);

        // Stall: fill skid, hold off C, then drain in order
        dn.ready = 1'b0;
        send(8'hA1, 101'hAAA);
        @(negedge clk);
        chk("t3_a_ctrl", dn.ctrl, 8'hA1);
        send(8'hB2, 101'hBBB);
        @(negedge clk);
        chk("t3_full_occ", occupancy, 2'd2);
        chk("t3_full_rdy", up.ready, 1'b0);
        chk("t3_a_stable", dn.ctrl, 8'hA1);
        send(8'hC3, 101'hCCC);
        @(negedge clk);
        chk("t3_c_held_occ", occupancy, 2'd2);
        chk("t3_a_still", dn.data, 101'hAAA);
        dn.ready = 1'b1;
        @(negedge clk);
        chk("t3_b_out", dn.ctrl, 8'hB2);
        chk("t3_b_occ", occupancy, 2'd1);
        @(negedge clk);
        chk("t3_c_out", dn.data, 101'hCCC);
        up.valid = 1'b0;
        @(negedge clk);
        chk("t3_drained", dn.valid, 1'b0);

        // Flush from FULL with a concurrent input
        dn.ready = 1'b0;
        send(8'h11, 101'h111); @(negedge clk);
        send(8'h22, 101'h222); @(negedge clk);
        chk("t4_full", occupancy, 2'd2);
        flush = 1'b1; send(8'hFF, 101'hFFF);
        @(negedge clk);
        chk("t4_occ", occupancy, 2'd0);
        chk("t4_valid", dn.valid, 1'b0);
        chk("t4_ctrl", dn.ctrl, 8'h00);
        chk("t4_rdy", up.ready, 1'b1);
        flush = 1'b0; up.valid = 1'b0; dn.ready = 1'b1;
        @(negedge clk);
        chk("t4_no_ff", dn.valid, 1'b0);

        // Reset from FULL overrides flush and transfers
        dn.ready = 1'b0;
        send(8'h33, 101'h333); @(negedge clk);
        send(8'h44, 101'h444); @(negedge clk);
        reset = 1'b1; flush = 1'b1; send(8'h55, 101'h555); dn.ready = 1'b1;
        @(negedge clk);
        chk("t5_valid", dn.valid, 1'b0);
        chk("t5_ctrl", dn.ctrl, 8'h00);
        chk("t5_data", dn.data, '0);
        chk("t5_occ", occupancy, 2'd0);
        chk("t5_rdy", up.ready, 1'b1);
        reset = 1'b0; flush = 1'b0;
        send(8'h77, 101'h777);
        @(negedge clk);
        chk("t5_after_valid", dn.valid, 1'b1);
        chk("t5_after_ctrl", dn.ctrl, 8'h77);
        up.valid = 1'b0;
        @(negedge clk);

        // Random traffic; the per-cycle model compare does the checking
        for (int i = 0; i < 1000; i++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            up.valid = ($urandom_range(0, 3) != 0);
            up.ctrl  = CW'($urandom());
            up.data  = rnd[DW-1:0];
            dn.ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        up.valid = 1'b0; flush = 1'b0; dn.ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("final_empty", occupancy, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register that replaces the fixed-field stage registers (IF/ID, ID/EX, EX/ME, ME/WB).
- Carries a control bundle and a data bundle between two stages using a valid/ready handshake.
- Contains a 2-entry skid buffer so that in_ready is a registered signal, while still sustaining one transfer per cycle.
- Supports flush (bubble insertion) and guarantees that control bits are zero whenever the stage holds a bubble.

Parameters:
- CTRL_W, 8, width of control bundle (reg_write, mem_to_reg, mem_write, ...); forced to 0 on bubbles.
- DATA_W, 101, width of data bundle (ALU result, store data, write reg, branch target, ...); not cleared on bubbles.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous; empties the stage and discards the input of this cycle
- in_valid  input  1  upstream has a valid bundle
- in_ready  output  1  stage can accept; registered
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream data bundle
- out_valid  output  1  out_ctrl/out_data hold a valid bundle
- out_ready  input  1  downstream accepts
- out_ctrl  output  CTRL_W  control bundle; 0 when out_valid=0
- out_data  output  DATA_W  data bundle
- occupancy  output  2  number of entries held: 0, 1 or 2

Behaviour:
- Clock and reset:
  - Single clock domain; one clock and one reset only.
  - Reset is synchronous and active-high.
- Definitions:
  - Input transfer (acc) = in_valid & in_ready.
  - Output transfer (fire) = out_valid & out_ready.
  - The internal state is a main register (drives the outputs) plus a skid register.
- States, encoded by occupancy:
  - EMPTY (0): out_valid=0, in_ready=1.
  - ONE (1): out_valid=1, in_ready=1.
  - FULL (2): out_valid=1, in_ready=0.
- Transitions (evaluated at the rising edge when reset=0 and flush=0):
  - EMPTY & acc: main<=in, go to ONE.
  - EMPTY & !acc: stay EMPTY.
  - ONE & acc & fire: main<=in, stay ONE.
  - ONE & acc & !fire: skid<=in, go to FULL. Main is unchanged.
  - ONE & !acc & fire: go to EMPTY, out_ctrl<=0.
  - ONE & !acc & !fire: hold.
  - FULL & fire: main<=skid, go to ONE.
  - FULL & !fire: hold.
  - In FULL, in_valid is ignored because in_ready=0.
- Ordering: bundles leave in arrival order; none is dropped or duplicated except by flush.
- Latency: a bundle accepted at edge N is presented at out_* after edge N when the stage was EMPTY, or when it was ONE with fire in the same cycle.
- Throughput: one bundle per cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, out_ctrl and out_data hold stable.
- Flush (reset=0, flush=1):
  - Next state is EMPTY, out_valid<=0, out_ctrl<=0, in_ready<=1.
  - Both entries are discarded.
  - An input transfer in the same cycle is discarded, even though in_ready may be 1.
  - out_data holds its last value (don't-care).
- Reset (reset=1):
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 after the edge.
  - Skid register is cleared.
  - Reset overrides flush and any transfer.
  - Reset mid-operation (ONE or FULL) discards all contents.
  - in_ready is 1 in the first cycle after reset is released.
- Invariants:
  - out_valid=0 implies out_ctrl=0.
  - in_ready == (occupancy != 2), all signals registered.
  - occupancy is never 3.
  - No combinational path from out_ready to in_ready, or from in_* to out_*.

Test Plan:
1. Reset, then in_valid=1 with in_ctrl=0x5A, in_data=0x1234 for one cycle, out_ready=1 -> out_valid=1, out_ctrl=0x5A, out_data=0x1234 one cycle later; occupancy goes 0->1->0.
2. Stream 8 bundles (ctrl=i, data=0x100+i) back-to-back with out_ready=1 -> 8 consecutive out_valid cycles in order, in_ready stays 1, occupancy stays 1.
3. Hold out_ready=0 and send A then B -> occupancy=2 and in_ready=0 after the second edge, in_valid C is held off, out shows A stable. Release out_ready -> outputs A, B, C in order with no loss.
4. From FULL, assert flush together with in_valid=1 (ctrl=0xFF) -> next cycle occupancy=0, out_valid=0, out_ctrl=0x00, in_ready=1; bundle 0xFF never appears at the output.
5. From FULL, assert reset together with flush, in_valid and out_ready -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1; first bundle after release passes normally.
6. Randomised in_valid and out_ready (1000 cycles) with a scoreboard -> output sequence equals accepted input sequence, out_ctrl=0 whenever out_valid=0, and in_ready==(occupancy!=2) every cycle.
